bench_bist_harness: RTL and testbench



---
 rtl/bist_pkg.sv | 82 ++++++++
 rtl/bench_bist_harness_if.sv | 35 +++
 rtl/bist_lfsr.sv | 47 ++++
 rtl/bench_bist_harness.sv | 197 +++++++++++++++++++
 tb/tb_bench_bist_harness.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Purpose : Shared types and helpers for the built-in self-test harness that
//           drives a combinational benchmark netlist with pseudo-random
//           patterns and compacts its responses into a signature.
// Contents: state_t        - harness FSM states
//           default_mask() - Galois feedback masks for widths 8..32
//           galois_step()  - one Galois shift step (used for constants)
//           clog2()        - ceiling log2 for counter sizing
// ---------------------------------------------------------------------------
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Low-order feedback taps (the x^W term is implicit). Width 13 is the
   // pattern generator default; width 16 is the CCITT polynomial used for
   // response compaction, the rest are maximal-length polynomials.
   function automatic logic [31:0] default_mask(input int unsigned w);
      logic [31:0] m;
      case (w)
         32'd8:   m = 32'h0000_001D;
         32'd9:   m = 32'h0000_0011;
         32'd10:  m = 32'h0000_0009;
         32'd11:  m = 32'h0000_0005;
         32'd12:  m = 32'h0000_0053;
         32'd13:  m = 32'h0000_001B;
         32'd14:  m = 32'h0000_002B;
         32'd15:  m = 32'h0000_0003;
         32'd16:  m = 32'h0000_1021;
         32'd17:  m = 32'h0000_0009;
         32'd18:  m = 32'h0000_0081;
         32'd19:  m = 32'h0000_0027;
         32'd20:  m = 32'h0000_0009;
         32'd21:  m = 32'h0000_0005;
         32'd22:  m = 32'h0000_0003;
         32'd23:  m = 32'h0000_0021;
         32'd24:  m = 32'h0000_0087;
         32'd25:  m = 32'h0000_0009;
         32'd26:  m = 32'h0000_0047;
         32'd27:  m = 32'h0000_0027;
         32'd28:  m = 32'h0000_0009;
         32'd29:  m = 32'h0000_0005;
         32'd30:  m = 32'h0000_0053;
         32'd31:  m = 32'h0000_0009;
         32'd32:  m = 32'h0040_0007;
         default: m = 32'h0000_0000;
      endcase
      return m;
   endfunction

   // One Galois step of a w-bit register: shift left, fold the MSB back
   // through the mask.
   function automatic logic [31:0] galois_step(input logic [31:0] s,
                                               input logic [31:0] mask,
                                               input int unsigned w);
      logic [31:0] keep;
      logic [31:0] r;
      keep = (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      r    = (s << 1) & keep;
      if (s[w - 32'd1]) begin
         r = r ^ mask;
      end else begin
         r = r;
      end
      return r & keep;
   endfunction

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 32'd0;
      while ((32'd1 << r) < v) begin
         r = r + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bench_bist_harness_if.sv
// ---------------------------------------------------------------------------
// bench_bist_harness_if
// Purpose : Bundles the run control, golden/result and DUT-facing pattern and
//           response signals of the BIST harness.
// Signals : start, abort, golden_i       - run control / expected signature
//           resp_i                       - benchmark outputs f1..f16
//           pat_o                        - benchmark inputs x0..x12
//           busy, done, pass, signature  - run status and result
// Modports: master - the side driving control and responses (bench / host)
//           slave  - the harness itself
// ---------------------------------------------------------------------------
interface bench_bist_harness_if #(
   parameter int unsigned N_IN  = 13,
   parameter int unsigned N_OUT = 16
);
   logic             start;
   logic             abort;
   logic [N_OUT-1:0] golden_i;
   logic [N_OUT-1:0] resp_i;
   logic [N_IN-1:0]  pat_o;
   logic             busy;
   logic             done;
   logic             pass;
   logic [N_OUT-1:0] signature;

   modport master (
      output start, abort, golden_i, resp_i,
      input  pat_o, busy, done, pass, signature
   );

   modport slave (
      input  start, abort, golden_i, resp_i,
      output pat_o, busy, done, pass, signature
   );
endinterface

// File: rtl/bist_lfsr.sv
// ---------------------------------------------------------------------------
// bist_lfsr
// Purpose : W-bit Galois shift register with parallel injection. Used as the
//           pattern generator (inj tied to zero) and as the MISR (inj fed
//           with the benchmark response).
// Ports   : clk, rst_n   - clock, async active-low reset (clears to zero)
//           load         - synchronous load of load_val (wins over en)
//           load_val     - value loaded on load
//           en           - advance one step
//           inj          - word XORed into the next state on each step
//           q            - register contents
// ---------------------------------------------------------------------------
module bist_lfsr
   import bist_pkg::*;
#(
   parameter int unsigned   W    = 16,
   parameter logic [W-1:0]  MASK = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] inj,
   output logic [W-1:0] q
);

   logic [W-1:0] q_r;
   logic [W-1:0] nxt_s;

   assign nxt_s = {q_r[W-2:0], 1'b0} ^ (q_r[W-1] ? MASK : {W{1'b0}}) ^ inj;
   assign q     = q_r;

   // Shift register state: load has priority over stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= {W{1'b0}};
      end else if (load) begin
         q_r <= load_val;
      end else if (en) begin
         q_r <= nxt_s;
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/bench_bist_harness.sv
// ---------------------------------------------------------------------------
// bench_bist_harness
// Purpose : Stimulus/response harness for a generated combinational
//           benchmark. A run applies PAT_COUNT pseudo-random patterns, waits
//           DUT_LAT cycles for the pipeline to empty, compacts every response
//           into a MISR and compares the final signature with golden_i.
// Ports   : clk, rst_n - clock, async active-low reset
//           bus        - bench_bist_harness_if.slave (start, abort, golden_i,
//                        resp_i in; pat_o, busy, done, pass, signature out)
// ---------------------------------------------------------------------------
module bench_bist_harness
   import bist_pkg::*;
#(
   parameter int unsigned      N_IN      = 13,
   parameter int unsigned      N_OUT     = 16,
   parameter int unsigned      PAT_COUNT = 1024,
   parameter logic [N_IN-1:0]  LFSR_MASK = 13'h001B,
   parameter logic [N_OUT-1:0] MISR_MASK = 16'h1021,
   parameter logic [N_IN-1:0]  SEED      = 13'h0001,
   parameter int unsigned      DUT_LAT   = 0
) (
   input logic                 clk,
   input logic                 rst_n,
   bench_bist_harness_if.slave bus
);

   // An all-zero seed would lock the generator, so it is replaced by 1.
   localparam logic [N_IN-1:0] SEED_EFF =
      (SEED == {N_IN{1'b0}}) ? {{(N_IN-1){1'b0}}, 1'b1} : SEED;
   // The pattern LFSR runs one step ahead of pat_o, so it starts at the
   // successor of the seed while pat_o starts at the seed itself.
   localparam logic [N_IN-1:0] SEED_NXT =
      N_IN'(galois_step(32'(SEED_EFF), 32'(LFSR_MASK), N_IN));
   localparam int unsigned CNT_MAX = (PAT_COUNT > DUT_LAT) ? PAT_COUNT : DUT_LAT;
   localparam int unsigned CNT_W   = clog2(CNT_MAX + 32'd1);
   localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(PAT_COUNT - 32'd1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DUT_LAT > 32'd0) ? (DUT_LAT - 32'd1) : 32'd0);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [N_IN-1:0]  pat_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;

   logic             start_ok_s;
   logic             abort_act_s;
   logic             run_s;
   logic             tap_s;
   logic             misr_en_s;
   logic [N_IN-1:0]  lfsr_q_s;
   logic [N_OUT-1:0] misr_q_s;

   assign run_s       = (state_r == RUN);
   assign abort_act_s = bus.abort && (state_r != IDLE);
   assign start_ok_s  = (state_r == IDLE) && bus.start && !bus.abort;
   // An abort freezes the signature at its partial value.
   assign misr_en_s   = tap_s && !abort_act_s;

   // Valid pipe: a response is captured DUT_LAT cycles after its pattern.
   // With no latency the capture happens at the end of the driving cycle.
   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign tap_s = run_s;
      end else begin : g_lat
         logic [DUT_LAT-1:0] pipe_r;

         // Shift a valid marker per RUN cycle; abort empties the pipe.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_r <= {DUT_LAT{1'b0}};
            end else if (abort_act_s) begin
               pipe_r <= {DUT_LAT{1'b0}};
            end else begin
               pipe_r[0] <= run_s;
               for (int i = 1; i < DUT_LAT; i++) begin
                  pipe_r[i] <= pipe_r[i-1];
               end
            end
         end

         assign tap_s = pipe_r[DUT_LAT-1];
      end
   endgenerate

   bist_lfsr #(.W(N_IN), .MASK(LFSR_MASK)) u_pat_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok_s),
      .load_val (SEED_NXT),
      .en       (run_s),
      .inj      ({N_IN{1'b0}}),
      .q        (lfsr_q_s)
   );

   bist_lfsr #(.W(N_OUT), .MASK(MISR_MASK)) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok_s),
      .load_val ({N_OUT{1'b0}}),
      .en       (misr_en_s),
      .inj      (bus.resp_i),
      .q        (misr_q_s)
   );

   // Run sequencer with registered pattern and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         pat_r   <= {N_IN{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= {CNT_W{1'b0}};
               if (start_ok_s) begin
                  state_r <= RUN;
                  pat_r   <= SEED_EFF;
                  busy_r  <= 1'b1;
                  pass_r  <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  pat_r   <= {N_IN{1'b0}};
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               if (abort_act_s) begin
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
                  pat_r   <= {N_IN{1'b0}};
                  busy_r  <= 1'b0;
                  pass_r  <= 1'b0;
               end else if (cnt_r == PAT_LAST) begin
                  cnt_r <= {CNT_W{1'b0}};
                  pat_r <= {N_IN{1'b0}};
                  if (DUT_LAT > 0) begin
                     state_r <= DRAIN;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
                  pat_r <= lfsr_q_s;
               end
            end
            DRAIN: begin
               pat_r <= {N_IN{1'b0}};
               if (abort_act_s) begin
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
                  pass_r  <= 1'b0;
               end else if (cnt_r == DRAIN_LAST) begin
                  state_r <= DONE;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               pat_r   <= {N_IN{1'b0}};
               busy_r  <= 1'b0;
               if (abort_act_s) begin
                  pass_r <= 1'b0;
               end else begin
                  pass_r <= (misr_q_s == bus.golden_i);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
               pat_r   <= {N_IN{1'b0}};
               busy_r  <= 1'b0;
               pass_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pat_o     = pat_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.signature = misr_q_s;

endmodule

// File: tb/tb_bench_bist_harness.sv
// ---------------------------------------------------------------------------
// tb_bench_bist_harness
// Purpose : Directed self-checking bench for bench_bist_harness. Two
//           instances with PAT_COUNT=4: u_dut0 (DUT_LAT=0, response from a
//           constant or a combinational loopback of pat_o) and u_dut2
//           (DUT_LAT=2, response from a two-stage register of pat_o).
// ---------------------------------------------------------------------------
module tb_bench_bist_harness;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bench_bist_harness_if #(.N_IN(13), .N_OUT(16)) if0 ();
   bench_bist_harness_if #(.N_IN(13), .N_OUT(16)) if2 ();

   bench_bist_harness #(.PAT_COUNT(4), .DUT_LAT(0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   bench_bist_harness #(.PAT_COUNT(4), .DUT_LAT(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] resp_const;
   logic        loop_mode;
   logic [12:0] d1_r;
   logic [12:0] d2_r;
   int          n;
   int          done_cnt;
   int          busy_cnt;
   int          done_at;

   logic [31:0] exp_pat  [4] = '{32'h0001, 32'h0002, 32'h0004, 32'h0008};
   logic [31:0] exp_loop [4] = '{32'h0001, 32'h0000, 32'h0004, 32'h0000};

   // Response model for the zero-latency instance.
   always_comb begin
      if0.resp_i = loop_mode ? {3'b000, if0.pat_o} : resp_const;
   end

   // Two-stage pipelined loopback for the latency instance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_r <= 13'h0000;
         d2_r <= 13'h0000;
      end else begin
         d1_r <= if2.pat_o;
         d2_r <= d1_r;
      end
   end
   assign if2.resp_i = {3'b000, d2_r};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0();
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
   endtask

   // Bounded wait for done on u_dut0; returns cycles since the start cycle.
   task automatic wait_done0(output int cyc);
      cyc = 1;
      while (if0.done !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      if0.start  = 1'b0;
      if0.abort  = 1'b0;
      if0.golden_i = 16'h0000;
      if2.start  = 1'b0;
      if2.abort  = 1'b0;
      if2.golden_i = 16'h0000;
      resp_const = 16'h0000;
      loop_mode  = 1'b0;

      // Reset state
      #2;
      check("rst_pat",  32'(if0.pat_o), 32'h0);
      check("rst_busy", 32'(if0.busy), 32'h0);
      check("rst_done", 32'(if0.done), 32'h0);
      check("rst_pass", 32'(if0.pass), 32'h0);
      check("rst_sig",  32'(if0.signature), 32'h0);
      check("rst_sig2", 32'(if2.signature), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Pattern sequence, zero response
      start0();
      for (int i = 0; i < 4; i++) begin
         check("seq_pat",  32'(if0.pat_o), exp_pat[i]);
         check("seq_busy", 32'(if0.busy), 32'h1);
         check("seq_done", 32'(if0.done), 32'h0);
         tick();
      end
      check("seq_done_pulse", 32'(if0.done), 32'h1);
      check("seq_busy_off",   32'(if0.busy), 32'h0);
      check("seq_pat_done",   32'(if0.pat_o), 32'h0);
      check("seq_sig",        32'(if0.signature), 32'h0000);
      tick();
      check("seq_done_once",  32'(if0.done), 32'h0);
      check("seq_pass",       32'(if0.pass), 32'h1);

      // Constant response 0x0001 -> signature 0x000F
      resp_const   = 16'h0001;
      if0.golden_i = 16'h000F;
      start0();
      check("const_pass_clr", 32'(if0.pass), 32'h0);
      wait_done0(n);
      check("const_latency", 32'(n), 32'd5);
      check("const_sig",     32'(if0.signature), 32'h000F);
      tick();
      check("const_pass",    32'(if0.pass), 32'h1);
      if0.golden_i = 16'h000E;
      start0();
      wait_done0(n);
      check("const_sig_b",   32'(if0.signature), 32'h000F);
      tick();
      check("const_fail_pass", 32'(if0.pass), 32'h0);

      // Loopback: per-step signature
      loop_mode    = 1'b1;
      if0.golden_i = 16'h0000;
      start0();
      check("loop_sig_clr", 32'(if0.signature), 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("loop_sig", 32'(if0.signature), exp_loop[i]);
      end
      check("loop_done", 32'(if0.done), 32'h1);
      tick();
      check("loop_pass", 32'(if0.pass), 32'h1);
      loop_mode = 1'b0;

      // Latency 2 with pipelined loopback
      if2.start = 1'b1;
      tick();
      if2.start = 1'b0;
      busy_cnt = 0;
      done_at  = 0;
      for (int i = 1; i <= 12; i++) begin
         if (if2.busy === 1'b1) busy_cnt++;
         if (if2.done === 1'b1 && done_at == 0) done_at = i;
         tick();
      end
      check("lat_busy_cycles", 32'(busy_cnt), 32'd6);
      check("lat_done_cycle",  32'(done_at), 32'd7);
      check("lat_sig",         32'(if2.signature), 32'h0000);
      check("lat_pass",        32'(if2.pass), 32'h1);

      // Abort in the 2nd RUN cycle
      resp_const   = 16'h0001;
      if0.golden_i = 16'h000F;
      start0();
      tick();
      if0.abort = 1'b1;
      tick();
      if0.abort = 1'b0;
      check("abort_busy", 32'(if0.busy), 32'h0);
      check("abort_pat",  32'(if0.pat_o), 32'h0);
      check("abort_pass", 32'(if0.pass), 32'h0);
      check("abort_sig",  32'(if0.signature), 32'h0001);
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (if0.done === 1'b1) done_cnt++;
         tick();
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);

      // abort and start together in IDLE: abort wins
      if0.start = 1'b1;
      if0.abort = 1'b1;
      tick();
      if0.start = 1'b0;
      if0.abort = 1'b0;
      check("abort_start_busy", 32'(if0.busy), 32'h0);
      check("abort_start_pat",  32'(if0.pat_o), 32'h0);

      // Clean rerun after abort
      start0();
      check("rerun_seed", 32'(if0.pat_o), 32'h0001);
      wait_done0(n);
      check("rerun_latency", 32'(n), 32'd5);
      check("rerun_sig",     32'(if0.signature), 32'h000F);
      tick();
      check("rerun_pass",    32'(if0.pass), 32'h1);

      // start during RUN is ignored
      start0();
      tick();
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      check("busy_start_pat", 32'(if0.pat_o), 32'h0004);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (if0.done === 1'b1) done_cnt++;
         tick();
      end
      check("busy_start_done_cnt", 32'(done_cnt), 32'd1);
      check("busy_start_pass",     32'(if0.pass), 32'h1);

      // Asynchronous reset mid-RUN
      start0();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("areset_busy", 32'(if0.busy), 32'h0);
      check("areset_pat",  32'(if0.pat_o), 32'h0);
      check("areset_sig",  32'(if0.signature), 32'h0);
      check("areset_pass", 32'(if0.pass), 32'h0);
      check("areset_done", 32'(if0.done), 32'h0);
      check("areset_pass2", 32'(if2.pass), 32'h0);
      #2;
      rst_n = 1'b1;
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if0.done === 1'b1) done_cnt++;
         if (if0.busy === 1'b1) busy_cnt++;
      end
      check("areset_no_done", 32'(done_cnt), 32'd0);
      check("areset_idle",    32'(busy_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
